bit_serial_subtractor: RTL

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

---
 rtl/bit_serial_subtractor.sv | 86 ++++++++
 1 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (A-B) mod 2^WIDTH one bit per clock, LSB first,
// through a three-state IDLE/RUN/FIN controller with a registered result and borrow.
module bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             En,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;

  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  // One full-subtractor cell; the new difference bit enters at the MSB so that
  // after WIDTH shifts the result register holds the word in natural order.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      Diff    <= '0;
      Borrow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (En) begin
            r_a     <= A;
            r_b     <= B;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + CW'(1);
          // The final bit is folded in directly so Diff/Borrow update on the last RUN edge.
          if (w_last) begin
            Diff    <= w_res_nxt;
            Borrow  <= w_br_nxt;
            r_state <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state == S_RUN) || (r_state == S_FIN);
  assign Done = (r_state == S_FIN);

endmodule
